// File: rtl/bram_fifo_pkg.sv
// Shared constants and word layout for the 36K block-RAM FIFO controller.
package bram_fifo_pkg;

  localparam int unsigned RAM36_ADDR_W     = 15;
  localparam int unsigned RAM36_WORD_SHIFT = 5;
  localparam int unsigned FIFO_W           = 36;

  typedef struct packed {
    logic [3:0]  parity;
    logic [31:0] data;
  } fifo_word_t;

endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry first-word-fall-through buffer that catches RAM read data.
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_capture,
  input  logic [FIFO_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [FIFO_W-1:0] o_data,
  output logic [1:0]        o_count,
  output logic [1:0]        o_count_nxt
);

  fifo_word_t r_mem [2];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  assign o_count_nxt = r_count + {1'b0, i_capture} - {1'b0, i_pop};
  assign o_count     = r_count;
  assign o_valid     = (r_count != 2'd0);
  assign o_data      = r_mem[r_head];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_capture) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= ~r_tail;
      end
      if (i_pop) r_head <= ~r_head;
      r_count <= o_count_nxt;
    end
  end

endmodule

// File: rtl/bram36k_fifo_ctrl.sv
// FIFO controller driving a TDP_RAM36K: port A writes, port B reads into
// a small FWFT output buffer.
module bram36k_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned AFULL_THRESH = 1020
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    PUSH_VALID,
  output logic                    PUSH_READY,
  input  logic [FIFO_W-1:0]       PUSH_DATA,
  output logic                    POP_VALID,
  input  logic                    POP_READY,
  output logic [FIFO_W-1:0]       POP_DATA,
  output logic [10:0]             LEVEL,
  output logic                    ALMOST_FULL,
  output logic                    WEN_A,
  output logic [3:0]              BE_A,
  output logic [RAM36_ADDR_W-1:0] ADDR_A,
  output logic [31:0]             WDATA_A,
  output logic [3:0]              WPARITY_A,
  output logic                    REN_B,
  output logic [RAM36_ADDR_W-1:0] ADDR_B,
  input  logic [31:0]             RDATA_B,
  input  logic [3:0]              RPARITY_B
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] RAM_FULL  = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [10:0]      AFULL_LVL = 11'(AFULL_THRESH);

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CNT_W-1:0]      r_ram_cnt;
  logic                  r_inflight;
  logic                  r_active;
  logic [10:0]           r_level;
  logic                  r_afull;

  logic [CNT_W-1:0] w_ram_cnt_nxt;
  logic [10:0]      w_level_nxt;
  logic [1:0]       w_out_cnt;
  logic [1:0]       w_out_cnt_nxt;
  logic [2:0]       w_occ;
  logic             w_push_ready;
  logic             w_push_fire;
  logic             w_pop_fire;
  logic             w_issue;
  fifo_word_t       w_cap_word;

  // Ready is held low for the first cycle out of reset via r_active.
  assign w_push_ready = r_active && (r_ram_cnt != RAM_FULL);
  assign w_push_fire  = PUSH_VALID && w_push_ready;
  assign w_pop_fire   = POP_VALID && POP_READY;

  // Buffer slots already claimed after this cycle's pop; issue only if one is free.
  assign w_occ   = {1'b0, w_out_cnt} + {2'b0, r_inflight} - {2'b0, w_pop_fire};
  assign w_issue = (r_ram_cnt != '0) && (w_occ < 3'd2);

  assign w_ram_cnt_nxt = r_ram_cnt + CNT_W'(w_push_fire) - CNT_W'(w_issue);
  assign w_level_nxt   = 11'(w_ram_cnt_nxt) + 11'(w_issue) + 11'(w_out_cnt_nxt);

  assign w_cap_word.parity = RPARITY_B;
  assign w_cap_word.data   = RDATA_B;

  assign PUSH_READY  = w_push_ready;
  assign WEN_A       = w_push_fire;
  assign BE_A        = {4{w_push_fire}};
  assign ADDR_A      = {r_wptr, {RAM36_WORD_SHIFT{1'b0}}};
  assign WDATA_A     = PUSH_DATA[31:0];
  assign WPARITY_A   = PUSH_DATA[35:32];
  assign REN_B       = w_issue;
  assign ADDR_B      = {r_rptr, {RAM36_WORD_SHIFT{1'b0}}};
  assign LEVEL       = r_level;
  assign ALMOST_FULL = r_afull;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_active   <= 1'b0;
      r_level    <= '0;
      r_afull    <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      if (w_push_fire) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_issue)     r_rptr <= r_rptr + DEPTH_LOG2'(1);
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_issue;
      r_level    <= w_level_nxt;
      r_afull    <= (w_level_nxt >= AFULL_LVL);
    end
  end

  bram_fifo_outbuf u_outbuf (
    .i_clk       (CLK),
    .i_rst_n     (RESET_N),
    .i_capture   (r_inflight),
    .i_data      (w_cap_word),
    .i_pop       (w_pop_fire),
    .o_valid     (POP_VALID),
    .o_data      (POP_DATA),
    .o_count     (w_out_cnt),
    .o_count_nxt (w_out_cnt_nxt)
  );

endmodule

// File: tb/tb_bram36k_fifo_ctrl.sv
// Bench for bram36k_fifo_ctrl: block-RAM model plus a queue reference of the FIFO contents.
module tb_bram36k_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PUSH_VALID;
  logic        PUSH_READY;
  logic [35:0] PUSH_DATA;
  logic        POP_VALID;
  logic        POP_READY;
  logic [35:0] POP_DATA;
  logic [10:0] LEVEL;
  logic        ALMOST_FULL;
  logic        WEN_A;
  logic [3:0]  BE_A;
  logic [14:0] ADDR_A;
  logic [31:0] WDATA_A;
  logic [3:0]  WPARITY_A;
  logic        REN_B;
  logic [14:0] ADDR_B;
  logic [31:0] RDATA_B;
  logic [3:0]  RPARITY_B;

  always #5 CLK = ~CLK;

  bram36k_fifo_ctrl #(.DEPTH_LOG2(10), .AFULL_THRESH(1020)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .PUSH_VALID(PUSH_VALID), .PUSH_READY(PUSH_READY), .PUSH_DATA(PUSH_DATA),
    .POP_VALID(POP_VALID), .POP_READY(POP_READY), .POP_DATA(POP_DATA),
    .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL),
    .WEN_A(WEN_A), .BE_A(BE_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A), .WPARITY_A(WPARITY_A),
    .REN_B(REN_B), .ADDR_B(ADDR_B), .RDATA_B(RDATA_B), .RPARITY_B(RPARITY_B)
  );

  // 1024 x 36 RAM with one-cycle read latency
  logic [35:0] ram [1024];
  always @(posedge CLK) begin
    if (WEN_A) ram[ADDR_A[14:5]] <= {WPARITY_A, WDATA_A};
    if (REN_B) {RPARITY_B, RDATA_B} <= ram[ADDR_B[14:5]];
  end

  logic [35:0] q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned wcnt = 0, rcnt = 0, tb_buf = 0;
  int unsigned push_acc = 0, pop_acc = 0;
  int          cyc = 0, first_push = -1, first_pop = -1, last_pop = -1;
  bit          prev_stall = 0;
  logic [35:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the model, records fires, advances one clock.
  task automatic tick();
    bit pf, of;
    logic [14:0] exp_a;
    #2;
    chk("level", LEVEL, q.size());
    chk("almost_full", ALMOST_FULL, q.size() >= 1020);
    if (q.size() < 1024) chk("push_ready", PUSH_READY, 1);
    if (q.size() == 1026) chk("push_ready_full", PUSH_READY, 0);
    if (q.size() == 0) chk("pop_valid_empty", POP_VALID, 0);
    if (POP_VALID && q.size() > 0) chk("pop_data", POP_DATA, q[0]);
    if (prev_stall) begin
      chk("stall_valid", POP_VALID, 1);
      chk("stall_data", POP_DATA, prev_data);
    end
    pf = PUSH_VALID && PUSH_READY;
    of = POP_VALID && POP_READY;
    chk("wen_a", WEN_A, pf);
    chk("be_a", BE_A, pf ? 4'hF : 4'h0);
    if (pf) begin
      exp_a = 15'(wcnt % 1024) << 5;
      chk("addr_a", ADDR_A, exp_a);
      chk("wdata_a", WDATA_A, PUSH_DATA[31:0]);
      chk("wparity_a", WPARITY_A, PUSH_DATA[35:32]);
    end
    if (REN_B) begin
      exp_a = 15'(rcnt % 1024) << 5;
      chk("ren_room", (tb_buf - of) < 2, 1);
      chk("addr_b", ADDR_B, exp_a);
      rcnt++;
      tb_buf++;
    end
    if (of) begin
      tb_buf--;
      pop_acc++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (pf) begin
      q.push_back(PUSH_DATA);
      wcnt++;
      push_acc++;
      if (first_push < 0) first_push = cyc;
    end
    prev_stall = POP_VALID && !POP_READY;
    prev_data  = POP_DATA;
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    cyc++;
    RESET_N = 1'b1; PUSH_VALID = 1'b0; POP_READY = 1'b0;
    q.delete(); wcnt = 0; rcnt = 0; tb_buf = 0; prev_stall = 0;
    #2;
    chk("rst_pop_valid", POP_VALID, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_push_ready", PUSH_READY, 0);
    chk("rst_almost_full", ALMOST_FULL, 0);
    chk("rst_pop_data", POP_DATA, 0);
    chk("rst_ren_b", REN_B, 0);
    chk("rst_wen_a", WEN_A, 0);
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic drain(input int unsigned budget);
    PUSH_VALID = 1'b0; POP_READY = 1'b1;
    for (int i = 0; i < budget && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    RESET_N = 1'b0; PUSH_VALID = 1'b0; POP_READY = 1'b0; PUSH_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Single word through an empty FIFO: check pipeline timing.
    PUSH_VALID = 1'b1; PUSH_DATA = 36'h9_DEADBEEF;
    #1;
    chk("first_wen", WEN_A, 1);
    chk("first_addr_a", ADDR_A, 0);
    chk("first_be", BE_A, 4'hF);
    chk("first_parity", WPARITY_A, 4'h9);
    tick();
    PUSH_VALID = 1'b0;
    #1; chk("first_ren", REN_B, 1); chk("first_addr_b", ADDR_B, 0);
    tick();
    #1; chk("first_not_yet", POP_VALID, 0);
    tick();
    #1;
    chk("first_pop_valid", POP_VALID, 1);
    chk("first_pop_data", POP_DATA, 36'h9_DEADBEEF);
    chk("first_level", LEVEL, 1);
    tick();
    drain(10);

    // Continuous streaming, crossing the pointer wrap.
    pop_acc = 0; first_push = -1; first_pop = -1; last_pop = -1;
    POP_READY = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      PUSH_VALID = 1'b1; PUSH_DATA = 36'(i + 'h100);
      tick();
    end
    drain(20);
    chk("stream_pops", pop_acc, 2000);
    chk("stream_latency", first_pop - first_push, 3);
    chk("stream_gapless", last_pop - first_pop + 1, 2000);

    // Fill to capacity with the consumer stalled.
    POP_READY = 1'b0; push_acc = 0;
    for (int i = 0; i < 1100; i++) begin
      PUSH_VALID = 1'b1; PUSH_DATA = 36'h5_0000_0000 | 36'(i);
      #1;
      if (!PUSH_READY) break;
      tick();
    end
    PUSH_VALID = 1'b0;
    tick();
    chk("fill_count", push_acc, 1026);
    #1; chk("fill_level", LEVEL, 1026); chk("fill_afull", ALMOST_FULL, 1);
    tick();
    POP_READY = 1'b1;
    tick();
    POP_READY = 1'b0;
    ok = 0;
    for (int i = 0; i < 2 && !ok; i++) begin
      #1;
      if (PUSH_READY) ok = 1;
      tick();
    end
    chk("ready_after_pop", ok, 1);
    drain(1100);

    // Random push/pop traffic.
    push_acc = 0; pop_acc = 0;
    for (int i = 0; i < 6000 && push_acc < 300; i++) begin
      PUSH_VALID = ($urandom_range(0, 9) < 7);
      PUSH_DATA  = {4'($urandom), 32'($urandom)};
      POP_READY  = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_pushed", push_acc, 300);
    drain(400);
    chk("rand_popped", pop_acc, 300);

    // Reset while a read is in flight.
    POP_READY = 1'b0;
    for (int i = 0; i < 50; i++) begin
      PUSH_VALID = 1'b1; PUSH_DATA = {4'hA, 32'($urandom)};
      tick();
    end
    PUSH_VALID = 1'b0;
    repeat (4) tick();
    chk("pre_rst_level", LEVEL, 50);
    POP_READY = 1'b1; RESET_N = 1'b0;
    #1; chk("ren_at_reset", REN_B, 1);
    do_reset();
    #1; chk("rst_ready_back", PUSH_READY, 1);
    POP_READY = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      PUSH_VALID = 1'b1; PUSH_DATA = 36'h3_0000_0000 | 36'(i);
      tick();
    end
    drain(10);

    // Simultaneous push and pop at LEVEL=1.
    POP_READY = 1'b0;
    PUSH_VALID = 1'b1; PUSH_DATA = 36'h1_1111_1111;
    tick();
    PUSH_VALID = 1'b0;
    for (int i = 0; i < 6 && !POP_VALID; i++) tick();
    #1; chk("simul_pre_valid", POP_VALID, 1); chk("simul_pre_level", LEVEL, 1);
    PUSH_VALID = 1'b1; PUSH_DATA = 36'h2_2222_2222; POP_READY = 1'b1;
    tick();
    PUSH_VALID = 1'b0; POP_READY = 1'b0;
    #1; chk("simul_level", LEVEL, 1);
    tick();
    for (int i = 0; i < 6 && !POP_VALID; i++) tick();
    #1; chk("simul_next_data", POP_DATA, 36'h2_2222_2222);
    tick();
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
